// File: rtl/dds_param_scheduler.sv
// Timed DDS parameter scheduler: buffers (time, freq, phase) commands and
// loads each into the phase-MAC operand registers when its apply time arrives.
module dds_param_scheduler #(
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [47:0]      s_time,
   input  logic [47:0]      s_freq,
   input  logic [13:0]      s_phase,
   input  logic             flush,
   input  logic             ts_clear,
   input  logic             clear_late,
   output logic [47:0]      timestamp,
   output logic [47:0]      time_offset,
   output logic [47:0]      freq,
   output logic [13:0]      phase,
   output logic             update,
   output logic             late,
   output logic             late_flag,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [47:0]      r_memTime  [DEPTH];
   logic [47:0]      r_memFreq  [DEPTH];
   logic [13:0]      r_memPhase [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [LVL_W-1:0] r_level;
   logic             r_ready;
   logic [47:0]      r_timestamp;
   logic [47:0]      r_timeOffset;
   logic [47:0]      r_freq;
   logic [13:0]      r_phase;
   logic             r_update;
   logic             r_late;
   logic             r_lateFlag;

   logic [47:0]      w_headTime;
   logic [47:0]      w_headFreq;
   logic [13:0]      w_headPhase;
   logic             w_write;
   logic             w_apply;
   logic             w_isLate;
   logic [LVL_W-1:0] w_levelNext;

   assign w_headTime  = r_memTime[r_rdPtr];
   assign w_headFreq  = r_memFreq[r_rdPtr];
   assign w_headPhase = r_memPhase[r_rdPtr];

   assign w_write  = s_valid && r_ready && !flush;
   // Compare uses the current counter value, even in a ts_clear cycle.
   assign w_apply  = (r_level != '0) && (w_headTime <= r_timestamp) && !flush;
   assign w_isLate = w_headTime < r_timestamp;

   always_comb begin
      w_levelNext = r_level;
      if (flush) begin
         w_levelNext = '0;
      end else if (w_write && !w_apply) begin
         w_levelNext = r_level + LVL_W'(1);
      end else if (!w_write && w_apply) begin
         w_levelNext = r_level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_memTime[r_wrPtr]  <= s_time;
         r_memFreq[r_wrPtr]  <= s_freq;
         r_memPhase[r_wrPtr] <= s_phase;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
         r_ready <= 1'b0;
      end else begin
         if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
         end else begin
            if (w_write) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_apply) r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         r_level <= w_levelNext;
         r_ready <= w_levelNext < LVL_W'(DEPTH);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_timestamp  <= '0;
         r_timeOffset <= '0;
         r_freq       <= '0;
         r_phase      <= '0;
         r_update     <= 1'b0;
         r_late       <= 1'b0;
         r_lateFlag   <= 1'b0;
      end else begin
         r_timestamp <= ts_clear ? '0 : r_timestamp + 48'd1;
         r_update    <= w_apply;
         r_late      <= w_apply && w_isLate;
         if (w_apply) begin
            r_timeOffset <= w_headTime;
            r_freq       <= w_headFreq;
            r_phase      <= w_headPhase;
         end
         // A late apply in the same cycle overrides clear_late.
         if (w_apply && w_isLate) begin
            r_lateFlag <= 1'b1;
         end else if (clear_late) begin
            r_lateFlag <= 1'b0;
         end
      end
   end

   assign s_ready     = r_ready;
   assign level       = r_level;
   assign timestamp   = r_timestamp;
   assign time_offset = r_timeOffset;
   assign freq        = r_freq;
   assign phase       = r_phase;
   assign update      = r_update;
   assign late        = r_late;
   assign late_flag   = r_lateFlag;

endmodule

// File: tb/tb_dds_param_scheduler.sv
// Directed bench for dds_param_scheduler with hand-computed expectations.
module tb_dds_param_scheduler;

   localparam int DEPTH = 16;
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             resetn;
   logic             s_valid;
   logic             s_ready;
   logic [47:0]      s_time;
   logic [47:0]      s_freq;
   logic [13:0]      s_phase;
   logic             flush;
   logic             ts_clear;
   logic             clear_late;
   logic [47:0]      timestamp;
   logic [47:0]      time_offset;
   logic [47:0]      freq;
   logic [13:0]      phase;
   logic             update;
   logic             late;
   logic             late_flag;
   logic [LVL_W-1:0] level;

   int          nVec = 0;
   int          nErr = 0;
   logic [47:0] ts;

   dds_param_scheduler #(.DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_time(s_time), .s_freq(s_freq), .s_phase(s_phase),
      .flush(flush), .ts_clear(ts_clear), .clear_late(clear_late),
      .timestamp(timestamp), .time_offset(time_offset),
      .freq(freq), .phase(phase),
      .update(update), .late(late), .late_flag(late_flag), .level(level)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; the bench tracks the expected timestamp itself.
   task automatic tick();
      @(posedge clk);
      ts = ts_clear ? 48'd0 : ts + 48'd1;
      #1;
   endtask

   task automatic runTo(input logic [47:0] target);
      for (int i = 0; i < 5000 && ts != target; i++) tick();
      checkOutput("runTo", timestamp, target);
   endtask

   task automatic applyStimulus(input logic v, input logic [47:0] t, input logic [47:0] f, input logic [13:0] p);
      s_valid = v;
      s_time  = t;
      s_freq  = f;
      s_phase = p;
   endtask

   initial begin
      resetn = 1'b0;
      flush = 1'b0; ts_clear = 1'b0; clear_late = 1'b0;
      applyStimulus(1'b0, 48'd0, 48'd0, 14'd0);
      ts = 48'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready", {47'd0, s_ready}, 48'd0);
      checkOutput("rst_ts", timestamp, 48'd0);
      checkOutput("rst_level", {{(48-LVL_W){1'b0}}, level}, 48'd0);
      resetn = 1'b1;
      tick();
      checkOutput("rel_ready", {47'd0, s_ready}, 48'd1);
      checkOutput("rel_ts1", timestamp, 48'd1);
      tick();
      checkOutput("rel_ts2", timestamp, 48'd2);

      // Future command at timestamp 10
      runTo(48'd10);
      applyStimulus(1'b1, 48'd100, 48'h1234_5678_9ABC, 14'h2AB);
      tick();
      applyStimulus(1'b0, 48'd0, 48'd0, 14'd0);
      checkOutput("fut_level1", {{(48-LVL_W){1'b0}}, level}, 48'd1);
      runTo(48'd100);
      checkOutput("fut_noupd", {47'd0, update}, 48'd0);
      checkOutput("fut_freq_old", freq, 48'd0);
      tick();
      checkOutput("fut_ts", timestamp, 48'd101);
      checkOutput("fut_upd", {47'd0, update}, 48'd1);
      checkOutput("fut_toff", time_offset, 48'd100);
      checkOutput("fut_freq", freq, 48'h1234_5678_9ABC);
      checkOutput("fut_phase", {34'd0, phase}, 48'h2AB);
      checkOutput("fut_late", {47'd0, late}, 48'd0);
      checkOutput("fut_level0", {{(48-LVL_W){1'b0}}, level}, 48'd0);
      tick();
      checkOutput("fut_updpulse", {47'd0, update}, 48'd0);

      // Late drain at timestamp 50
      ts_clear = 1'b1;
      tick();
      ts_clear = 1'b0;
      checkOutput("clr_ts", timestamp, 48'd0);
      runTo(48'd50);
      applyStimulus(1'b1, 48'd5, 48'h5, 14'h5);
      tick();
      checkOutput("late_lvl", {{(48-LVL_W){1'b0}}, level}, 48'd1);
      applyStimulus(1'b1, 48'd6, 48'h6, 14'h6);
      tick();
      checkOutput("late1_upd", {46'd0, update, late}, 48'd3);
      checkOutput("late1_toff", time_offset, 48'd5);
      checkOutput("late1_flag", {47'd0, late_flag}, 48'd1);
      checkOutput("late1_lvl", {{(48-LVL_W){1'b0}}, level}, 48'd1);
      applyStimulus(1'b1, 48'd7, 48'h7, 14'h7);
      clear_late = 1'b1;
      tick();
      clear_late = 1'b0;
      checkOutput("late2_upd", {46'd0, update, late}, 48'd3);
      checkOutput("late2_toff", time_offset, 48'd6);
      checkOutput("late2_setwins", {47'd0, late_flag}, 48'd1);
      applyStimulus(1'b0, 48'd0, 48'd0, 14'd0);
      tick();
      checkOutput("late3_upd", {46'd0, update, late}, 48'd3);
      checkOutput("late3_freq", freq, 48'h7);
      checkOutput("late3_lvl", {{(48-LVL_W){1'b0}}, level}, 48'd0);
      tick();
      checkOutput("late_end", {46'd0, update, late}, 48'd0);
      checkOutput("late_sticky", {47'd0, late_flag}, 48'd1);
      clear_late = 1'b1;
      tick();
      clear_late = 1'b0;
      checkOutput("late_cleared", {47'd0, late_flag}, 48'd0);

      // Full / backpressure, then flush
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 48'h8000_0000_0000, 48'(100 + i), 14'(i));
         tick();
      end
      checkOutput("full_ready", {47'd0, s_ready}, 48'd0);
      checkOutput("full_level", {{(48-LVL_W){1'b0}}, level}, 48'(DEPTH));
      tick();
      tick();
      checkOutput("full_noacc", {{(48-LVL_W){1'b0}}, level}, 48'(DEPTH));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      applyStimulus(1'b0, 48'd0, 48'd0, 14'd0);
      checkOutput("flush_level", {{(48-LVL_W){1'b0}}, level}, 48'd0);
      checkOutput("flush_ready", {47'd0, s_ready}, 48'd1);
      checkOutput("flush_held", time_offset, 48'd7);
      checkOutput("flush_noupd", {47'd0, update}, 48'd0);

      // Simultaneous write and apply at level 3
      ts_clear = 1'b1;
      tick();
      ts_clear = 1'b0;
      applyStimulus(1'b1, 48'd10, 48'hA, 14'hA);
      tick();
      applyStimulus(1'b1, 48'd20, 48'hB, 14'hB);
      tick();
      applyStimulus(1'b1, 48'd30, 48'hC, 14'hC);
      tick();
      applyStimulus(1'b0, 48'd0, 48'd0, 14'd0);
      runTo(48'd10);
      checkOutput("sim_lvl3", {{(48-LVL_W){1'b0}}, level}, 48'd3);
      applyStimulus(1'b1, 48'd40, 48'hD, 14'hD);
      tick();
      applyStimulus(1'b0, 48'd0, 48'd0, 14'd0);
      checkOutput("sim_lvlhold", {{(48-LVL_W){1'b0}}, level}, 48'd3);
      checkOutput("sim_A", freq, 48'hA);
      runTo(48'd20);
      tick();
      checkOutput("sim_B", freq, 48'hB);
      runTo(48'd30);
      tick();
      checkOutput("sim_C", freq, 48'hC);
      runTo(48'd40);
      tick();
      checkOutput("sim_D", freq, 48'hD);
      checkOutput("sim_Dtoff", time_offset, 48'd40);
      checkOutput("sim_lvl0", {{(48-LVL_W){1'b0}}, level}, 48'd0);

      // ts_clear with a pending command for time 3
      runTo(48'd1000);
      applyStimulus(1'b1, 48'd3, 48'h33, 14'h3);
      ts_clear = 1'b1;
      tick();
      ts_clear = 1'b0;
      applyStimulus(1'b0, 48'd0, 48'd0, 14'd0);
      checkOutput("tsc_ts0", timestamp, 48'd0);
      checkOutput("tsc_lvl", {{(48-LVL_W){1'b0}}, level}, 48'd1);
      runTo(48'd3);
      checkOutput("tsc_wait", {47'd0, update}, 48'd0);
      tick();
      checkOutput("tsc_ts4", timestamp, 48'd4);
      checkOutput("tsc_upd", {46'd0, update, late}, 48'd2);
      checkOutput("tsc_toff", time_offset, 48'd3);

      // Counter wrap
      @(negedge clk);
      force dut.r_timestamp = 48'hFFFF_FFFF_FFFE;
      #1;
      release dut.r_timestamp;
      ts = 48'hFFFF_FFFF_FFFE;
      tick();
      checkOutput("wrap_max", timestamp, 48'hFFFF_FFFF_FFFF);
      tick();
      checkOutput("wrap_zero", timestamp, 48'd0);

      // Asynchronous reset mid-traffic
      applyStimulus(1'b1, 48'h8000_0000_0000, 48'h77, 14'h7);
      tick();
      @(negedge clk);
      resetn = 1'b0;
      #1;
      checkOutput("arst_level", {{(48-LVL_W){1'b0}}, level}, 48'd0);
      checkOutput("arst_ready", {47'd0, s_ready}, 48'd0);
      checkOutput("arst_ts", timestamp, 48'd0);
      checkOutput("arst_freq", freq, 48'd0);
      checkOutput("arst_toff", time_offset, 48'd0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("arst_hold_ts", timestamp, 48'd0);
      applyStimulus(1'b0, 48'd0, 48'd0, 14'd0);
      resetn = 1'b1;
      ts = 48'd0;
      tick();
      checkOutput("arst_rel_ready", {47'd0, s_ready}, 48'd1);
      checkOutput("arst_rel_ts", timestamp, 48'd1);
      tick();
      checkOutput("arst_rel_ts2", timestamp, 48'd2);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/dds_param_scheduler.md
# dds_param_scheduler

Timed parameter scheduler that feeds the DAC phase MAC. It accepts timed DDS commands (apply time, frequency, phase) over a valid/ready stream and buffers them in a small FIFO. It owns the free-running 48-bit timestamp counter. It drives the MAC's timeoffset, freq, phase and timestamp inputs, loading each buffered command on the cycle its apply time is reached.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..64
- LVL_W, $clog2(DEPTH+1), width of `level`

Ports:
- clk  in  1  single clock domain
- resetn  in  1  asynchronous, active-low reset
- s_valid  in  1  command valid
- s_ready  out  1  command accepted when s_valid && s_ready at a rising edge
- s_time  in  48  apply time, in timestamp units
- s_freq  in  48  frequency word
- s_phase  in  14  phase offset
- flush  in  1  synchronous; empties FIFO
- ts_clear  in  1  synchronous; timestamp restarts at 0
- clear_late  in  1  synchronous; clears late_flag
- timestamp  out  48  free-running counter (MAC D)
- time_offset  out  48  apply time of the active command (MAC A)
- freq  out  48  active frequency (MAC B)
- phase  out  14  active phase (MAC C)
- update  out  1  one-cycle pulse, first cycle new parameters are valid
- late  out  1  one-cycle pulse, coincident with update, when the applied command was late
- late_flag  out  1  sticky late indicator
- level  out  LVL_W  FIFO occupancy

## Operation
- Reset (resetn low, asynchronous): all outputs 0, including s_ready, FIFO empty, level 0. s_ready goes to 1 on the first edge after release.
- All outputs are registered. s_ready is registered: s_ready <= (level_next < DEPTH). There is no combinational path from s_valid to s_ready.
- timestamp increments by 1 every cycle and wraps 2^48-1 -> 0. There is no wrap compensation, and compares are plain unsigned.
- ts_clear: timestamp <= 0 at the next edge. The compare in that same cycle uses the old value. FIFO and outputs are unaffected.
- FIFO: register array with 48+48+14-bit entries, head read combinationally. A write occurs on s_valid && s_ready && !flush.
- Apply condition, evaluated every cycle: level != 0 && head.time <= timestamp && !flush. When it holds, at the edge:
  - time_offset <= head.time; freq <= head.freq; phase <= head.phase
  - pop head; update <= 1
  - late <= (head.time < timestamp)
  - late_flag <= 1 if late
- At most one apply per cycle. Queued commands whose times have already passed drain one per cycle, each flagged late.
- Same-cycle write and apply: both happen; level unchanged. A write into an empty FIFO cannot apply in the same cycle.
- flush: level <= 0 at the edge and any write in that cycle is dropped; s_ready <= 1 at that edge. Active parameters are held and update is not pulsed.
- clear_late: late_flag <= 0, unless a late apply occurs in the same cycle; setting wins.
- Commands apply in FIFO order only. An earlier-timed command behind a later one waits, then applies late.

## Timing
- Command accepted at edge e with s_time already reached: outputs load at edge e+1, and update is high in the cycle after e+1.
- Command with future time T queued at the head: it loads at the edge ending the cycle where timestamp == T. New parameters and update are visible while timestamp == T+1. The downstream MAC latency is fixed, so this 1-cycle offset is constant.
- level reflects all writes, pops and flushes one edge after the event.
- Full: s_ready falls at the edge where level reaches DEPTH. It rises one edge after the first pop or flush.

## Test plan
- Reset: hold resetn low for 5 cycles mid-traffic, asynchronously. Required: all outputs 0 immediately; s_ready 1 one edge after release; timestamp counts 0,1,2.
- Future command: push (time=100, freq=0x1234_5678_9ABC, phase=0x2AB) at timestamp 10. Required: outputs load and update pulses while timestamp==101; late stays 0; level goes 1 -> 0.
- Late drain: push times 5, 6, 7 while timestamp is 50. Required: three consecutive update pulses, each with late=1; late_flag set; clear_late clears it.
- Full/backpressure: push DEPTH commands with time=2^47 while holding s_valid. Required: s_ready low after the DEPTH-th accept; level==DEPTH; no further accepts. Then flush: level 0, outputs held, s_ready 1.
- Simultaneous write+apply: at level 3 with head due, also push. Required: level stays 3; FIFO order preserved on subsequent applies.
- Wrap/ts_clear: assert ts_clear with a command for time=3 pending at timestamp 1000. Required: it applies while timestamp==4. Separately, force the counter near 2^48-1 and check timestamp wraps to 0.
